// File: rtl/rbb_msg_reader.sv
// Memory-mapped master that drains red-bounding-box messages from the image processor FIFO.
// It publishes validated box edges with a one-cycle strobe and flushes the FIFO on framing errors.
module rbb_msg_reader #(
   parameter int unsigned POLL_CYCLES = 1024,
   parameter logic [31:0] MSG_ID      = 32'h0052_4242,
   parameter int unsigned MSG_WORDS   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        m_chipselect,
   output logic        m_read,
   output logic        m_write,
   output logic [2:0]  m_address,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   output logic [10:0] bb_left,
   output logic [10:0] bb_right,
   output logic        bb_none,
   output logic        bb_valid,
   output logic [7:0]  sync_err_count,
   output logic        busy
);

   localparam int unsigned TimerW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [TimerW-1:0] TimerLoad = TimerW'(POLL_CYCLES - 1);
   localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
   localparam logic [7:0]  MsgWords  = 8'(MSG_WORDS);
   localparam logic [2:0]  AddrStat  = 3'd0;
   localparam logic [2:0]  AddrMsg   = 3'd1;
   localparam logic [31:0] FlushCmd  = 32'h0000_0010;

   typedef enum logic [3:0] {
      StIdle,
      StStRd,
      StStCap,
      StIdRd,
      StIdCap,
      StW1Rd,
      StW1Cap,
      StW2Rd,
      StW2Cap,
      StPublish,
      StFlush
   } state_e;

   state_e            state;
   logic [TimerW-1:0] timer;
   logic [10:0]       xmin;
   logic [10:0]       xmax;
   logic              fmt_err;

   assign m_chipselect = m_read | m_write;

   // Every read state is followed by a capture state, so m_read is never high two cycles running.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= StIdle;
         timer          <= TimerLoad;
         m_read         <= 1'b0;
         m_write        <= 1'b0;
         m_address      <= AddrStat;
         m_writedata    <= '0;
         bb_left        <= '0;
         bb_right       <= '0;
         bb_none        <= 1'b1;
         bb_valid       <= 1'b0;
         sync_err_count <= '0;
         busy           <= 1'b0;
         xmin           <= '0;
         xmax           <= '0;
         fmt_err        <= 1'b0;
      end else begin
         m_read      <= 1'b0;
         m_write     <= 1'b0;
         m_address   <= AddrStat;
         m_writedata <= '0;
         bb_valid    <= 1'b0;

         unique case (state)
            StIdle: begin
               if (timer != '0) begin
                  timer <= timer - TimerOne;
               end else if (enable) begin
                  state     <= StStRd;
                  m_read    <= 1'b1;
                  m_address <= AddrStat;
                  busy      <= 1'b1;
               end
            end

            StStRd: state <= StStCap;

            StStCap: begin
               if (m_readdata[15:8] >= MsgWords) begin
                  state     <= StIdRd;
                  m_read    <= 1'b1;
                  m_address <= AddrMsg;
               end else begin
                  timer <= TimerLoad;
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end

            StIdRd: state <= StIdCap;

            StIdCap: begin
               if (m_readdata != MSG_ID) begin
                  state       <= StFlush;
                  m_write     <= 1'b1;
                  m_writedata <= FlushCmd;
                  if (sync_err_count != 8'hFF) sync_err_count <= sync_err_count + 8'd1;
               end else begin
                  state     <= StW1Rd;
                  m_read    <= 1'b1;
                  m_address <= AddrMsg;
               end
            end

            StW1Rd: state <= StW1Cap;

            StW1Cap: begin
               xmin      <= m_readdata[26:16];
               xmax      <= m_readdata[10:0];
               fmt_err   <= (m_readdata[31:27] != 5'd0) || (m_readdata[15:11] != 5'd0);
               state     <= StW2Rd;
               m_read    <= 1'b1;
               m_address <= AddrMsg;
            end

            StW2Rd: state <= StW2Cap;

            StW2Cap: begin
               if ((m_readdata != 32'd0) || fmt_err) begin
                  state       <= StFlush;
                  m_write     <= 1'b1;
                  m_writedata <= FlushCmd;
                  if (sync_err_count != 8'hFF) sync_err_count <= sync_err_count + 8'd1;
               end else begin
                  // bb_* change together with the strobe so consumers see a coherent box.
                  state    <= StPublish;
                  bb_left  <= xmin;
                  bb_right <= xmax;
                  bb_none  <= (xmin > xmax);
                  bb_valid <= 1'b1;
               end
            end

            StPublish, StFlush: begin
               timer <= TimerLoad;
               state <= StIdle;
               busy  <= 1'b0;
            end

            default: begin
               timer <= TimerLoad;
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rbb_msg_reader.sv
// Bench for rbb_msg_reader: FIFO slave model, transaction-level schedule model checked every
// cycle, and directed message scenarios with literal expectations.
module tb_rbb_msg_reader;

   localparam int unsigned POLL = 8;
   localparam logic [31:0] ID   = 32'h0052_4242;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        m_chipselect;
   logic        m_read;
   logic        m_write;
   logic [2:0]  m_address;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = 32'hA5A5_A5A5;
   logic [10:0] bb_left;
   logic [10:0] bb_right;
   logic        bb_none;
   logic        bb_valid;
   logic [7:0]  sync_err_count;
   logic        busy;

   always #5 clk = ~clk;

   rbb_msg_reader #(
      .POLL_CYCLES (POLL),
      .MSG_ID      (ID),
      .MSG_WORDS   (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .m_chipselect   (m_chipselect),
      .m_read         (m_read),
      .m_write        (m_write),
      .m_address      (m_address),
      .m_writedata    (m_writedata),
      .m_readdata     (m_readdata),
      .bb_left        (bb_left),
      .bb_right       (bb_right),
      .bb_none        (bb_none),
      .bb_valid       (bb_valid),
      .sync_err_count (sync_err_count),
      .busy           (busy)
   );

   int          n_tests = 0;
   int          n_fail = 0;
   longint      cyc = 0;
   logic [31:0] fifo[$];
   logic [7:0]  usedw;
   int          n_status = 0;
   int          n_msg_rd = 0;
   int          n_flush = 0;
   int          n_write = 0;
   int          n_valid = 0;
   longint      last_valid_cyc = -1;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Slave: status returns usedw in [15:8]; message reads pop; read data valid the next cycle.
   always @(posedge clk) begin
      if (m_read) begin
         if (m_address == 3'd0) begin
            usedw = 8'(fifo.size());
            m_readdata <= {16'h0, usedw, 8'h0};
            n_status++;
         end else begin
            n_msg_rd++;
            if (fifo.size() > 0) m_readdata <= fifo.pop_front();
            else m_readdata <= 32'h0;
         end
      end else begin
         m_readdata <= 32'hA5A5_A5A5;
      end
      if (m_write) begin
         n_write++;
         if (m_address == 3'd0 && m_writedata == 32'h10) begin
            fifo.delete();
            n_flush++;
         end
      end
      if (bb_valid) begin
         n_valid++;
         last_valid_cyc = cyc;
      end
      cyc++;
   end

   // Model: each poll is a transaction whose shape follows from the queued words.
   // kind 0 = too few words, 1 = bad header, 2 = bad body, 3 = good message.
   longint      plan_start = -1000;
   longint      plan_len = 0;
   int          plan_kind = 0;
   longint      due = 0;
   logic [10:0] exp_left = '0;
   logic [10:0] exp_right = '0;
   logic        exp_none = 1'b1;
   int          exp_err = 0;
   logic [10:0] nx_left = '0;
   logic [10:0] nx_right = '0;
   logic        nx_none = 1'b0;
   bit          rst_seen = 1'b0;
   logic        prev_read = 1'b0;

   always @(negedge clk) begin
      longint      k;
      bit          active;
      bit          e_read;
      bit          e_write;
      bit          e_valid;
      logic [2:0]  e_addr;
      logic [31:0] w1;
      k = cyc - plan_start;
      active = (k >= 0) && (k < plan_len);
      if (rst_seen) begin
         if (active && k == 0) begin
            if (fifo.size() < 3) begin
               plan_kind = 0;
               plan_len  = 2;
            end else begin
               w1 = fifo[1];
               if (fifo[0] != ID) begin
                  plan_kind = 1;
                  plan_len  = 5;
               end else if (w1[31:27] != 0 || w1[15:11] != 0 || fifo[2] != 0) begin
                  plan_kind = 2;
                  plan_len  = 9;
               end else begin
                  plan_kind = 3;
                  plan_len  = 9;
                  nx_left   = w1[26:16];
                  nx_right  = w1[10:0];
                  nx_none   = (w1[26:16] > w1[10:0]);
               end
            end
            due = plan_start + plan_len + POLL;
         end
         e_write = active && ((plan_kind == 1 && k == 4) || (plan_kind == 2 && k == 8));
         e_valid = active && plan_kind == 3 && k == 8;
         e_read  = active && (k == 0 || (plan_kind >= 1 && k == 2) ||
                              (plan_kind >= 2 && (k == 4 || k == 6)));
         e_addr  = (e_read && k != 0) ? 3'd1 : 3'd0;
         if (e_valid) begin
            exp_left  = nx_left;
            exp_right = nx_right;
            exp_none  = nx_none;
         end
         if (e_write && exp_err < 255) exp_err++;
         check("m_read", m_read, e_read);
         check("m_write", m_write, e_write);
         check("m_chipselect", m_chipselect, e_read | e_write);
         check("m_address", m_address, e_addr);
         if (e_write) check("m_writedata", m_writedata, 32'h10);
         check("busy", busy, active);
         check("bb_valid", bb_valid, e_valid);
         check("bb_left", bb_left, exp_left);
         check("bb_right", bb_right, exp_right);
         check("bb_none", bb_none, exp_none);
         check("sync_err_count", sync_err_count, exp_err);
         check("read_gap", prev_read & m_read, 0);
         prev_read = m_read;
      end
      if (reset) begin
         rst_seen   = 1'b1;
         plan_start = -1000;
         plan_len   = 0;
         due        = cyc + 1 + POLL;
         exp_left   = '0;
         exp_right  = '0;
         exp_none   = 1'b1;
         exp_err    = 0;
         prev_read  = 1'b0;
      end else if (rst_seen && (cyc + 1 >= plan_start + plan_len) && (cyc + 1 >= due) && enable) begin
         plan_start = cyc + 1;
         plan_len   = 1;
         plan_kind  = 0;
      end
   end

   task automatic wait_status(output longint t);
      int b;
      b = 0;
      do begin
         @(posedge clk);
         #1;
         b++;
      end while (!(m_read && m_address == 3'd0) && b < 4 * POLL + 40);
      check("status_read_seen", (m_read && m_address == 3'd0), 1);
      t = cyc;
   endtask

   // Pushes one message during the status-read cycle and waits for publish or flush.
   task automatic send(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                       input bit drop_en, output longint t0);
      int b;
      int v0;
      int f0;
      wait_status(t0);
      fifo.push_back(w0);
      fifo.push_back(w1);
      fifo.push_back(w2);
      if (drop_en) enable = 1'b0;
      v0 = n_valid;
      f0 = n_flush;
      b = 0;
      do begin
         @(posedge clk);
         #1;
         b++;
      end while (n_valid == v0 && n_flush == f0 && b < 30);
      check("msg_outcome_seen", (n_valid != v0) || (n_flush != f0), 1);
      enable = 1'b1;
   endtask

   initial begin
      longint t0;
      longint t1;
      longint t2;
      int     b_rd;
      int     b_fl;
      int     b_wr;
      int     b_v;
      int     b_st;
      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_read", m_read, 0);
      check("rst_busy", busy, 0);
      check("rst_bb_none", bb_none, 1);
      check("rst_bb_left", bb_left, 0);
      check("rst_err_count", sync_err_count, 0);
      reset = 1'b0;

      // Empty FIFO: only status reads, POLL+2 apart.
      wait_status(t0);
      wait_status(t1);
      wait_status(t2);
      check("poll_spacing_a", t1 - t0, POLL + 2);
      check("poll_spacing_b", t2 - t1, POLL + 2);
      check("empty_no_msg_reads", n_msg_rd, 0);
      check("empty_no_valid", n_valid, 0);

      // Good message 100..500.
      b_v = n_valid;
      send(ID, 32'h0064_01F4, 32'h0, 1'b0, t0);
      check("latency", last_valid_cyc - t0, 8);
      check("good_valid_count", n_valid - b_v, 1);
      check("good_left", bb_left, 100);
      check("good_right", bb_right, 500);
      check("good_none", bb_none, 0);

      // xmin > xmax means no red; enable dropped mid-message.
      send(ID, 32'h027F_0000, 32'h0, 1'b1, t0);
      check("none_left", bb_left, 639);
      check("none_right", bb_right, 0);
      check("none_flag", bb_none, 1);

      // Bad header: one message read, one flush, edges untouched.
      b_rd = n_msg_rd;
      b_fl = n_flush;
      b_wr = n_write;
      send(32'h0041_4141, 32'h0064_01F4, 32'h0, 1'b0, t0);
      repeat (3) @(posedge clk);
      #1;
      check("hdr_msg_reads", n_msg_rd - b_rd, 1);
      check("hdr_flushes", n_flush - b_fl, 1);
      check("hdr_writes", n_write - b_wr, 1);
      check("hdr_err_count", sync_err_count, 1);
      check("hdr_left_kept", bb_left, 639);
      check("hdr_none_kept", bb_none, 1);

      // Nonzero third word, then a reserved-bit error in word 1.
      b_v = n_valid;
      send(ID, 32'h0064_01F4, 32'h1, 1'b0, t0);
      check("w2_err_count", sync_err_count, 2);
      check("w2_no_valid", n_valid - b_v, 0);
      send(ID, 32'h8064_01F4, 32'h0, 1'b0, t0);
      check("w1_err_count", sync_err_count, 3);
      check("w1_no_valid", n_valid - b_v, 0);

      for (int i = 0; i < 256; i++) send(ID, 32'h0064_01F4, 32'h1, 1'b0, t0);
      check("err_saturated", sync_err_count, 255);
      check("sat_right_kept", bb_right, 0);

      // enable low at timer expiry holds the bus quiet.
      wait_status(t0);
      enable = 1'b0;
      repeat (2) @(posedge clk);
      b_st = n_status;
      b_wr = n_write;
      repeat (4 * POLL) @(posedge clk);
      #1;
      check("disabled_no_status", n_status - b_st, 0);
      check("disabled_no_write", n_write - b_wr, 0);
      enable = 1'b1;
      wait_status(t1);

      // Reset during W1_CAP abandons the message without a flush.
      b_fl = n_flush;
      b_v  = n_valid;
      wait_status(t0);
      fifo.push_back(ID);
      fifo.push_back(32'h0010_0020);
      fifo.push_back(32'h0);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rstmid_m_read", m_read, 0);
      check("rstmid_m_write", m_write, 0);
      check("rstmid_chipselect", m_chipselect, 0);
      check("rstmid_address", m_address, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_err_count", sync_err_count, 0);
      reset = 1'b0;
      fifo.delete();
      wait_status(t1);
      repeat (4) @(posedge clk);
      #1;
      check("rstmid_no_flush", n_flush - b_fl, 0);
      check("rstmid_no_valid", n_valid - b_v, 0);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
